// File: rtl/aes_key_schedule.sv
// AES-128 round-key generator: loads a key, then steps one registered round key per req_key cycle (rounds 0..NR).
// Optional AES_KEY_PRECOMPUTE_EN: after load, fills an 11-entry key bank over 10 cycles and replays the schedule from it.

module aes_key_sbox (
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte of the packed table.
   assign sub_val = SBOX[{~byte_val, 3'b000} +: 8];
endmodule

module aes_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [127:0] key_in,
   input  logic         load_key,
   output logic         key_ready,
   input  logic         req_key,
   input  logic         restart,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         round_valid,
   output logic         sched_done
);
`ifdef AES_KEY_PRECOMPUTE_EN
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE, EXPAND} state_t;
   localparam state_t LOAD_STATE = EXPAND;
`else
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   localparam state_t LOAD_STATE = ACTIVE;
`endif
   localparam logic [3:0] LAST_STEP = 4'(NR - 1);

   state_t       state, state_nxt;
   logic [127:0] key_reg;
   logic [127:0] exp_key;
   logic [127:0] step_key;
   logic [31:0]  rot_word, sub_word, g_word;
   logic [31:0]  n0, n1, n2, n3;
   logic [7:0]   rc;
   logic         load_acc;
   logic         step;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    rcon = 8'h01;
         4'd1:    rcon = 8'h02;
         4'd2:    rcon = 8'h04;
         4'd3:    rcon = 8'h08;
         4'd4:    rcon = 8'h10;
         4'd5:    rcon = 8'h20;
         4'd6:    rcon = 8'h40;
         4'd7:    rcon = 8'h80;
         4'd8:    rcon = 8'h1b;
         4'd9:    rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // One expansion step from the current round key; also drives the bank fill.
   assign rot_word = {round_key[23:0], round_key[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_key_sbox u_sbox (
         .byte_val (rot_word[8*i +: 8]),
         .sub_val  (sub_word[8*i +: 8])
      );
   end
   assign rc      = rcon(round_idx);
   assign g_word  = sub_word ^ {rc, 24'h0};
   assign n0      = round_key[127:96] ^ g_word;
   assign n1      = round_key[95:64]  ^ n0;
   assign n2      = round_key[63:32]  ^ n1;
   assign n3      = round_key[31:0]   ^ n2;
   assign exp_key = {n0, n1, n2, n3};

   assign load_acc = key_ready && load_key;

`ifdef AES_KEY_PRECOMPUTE_EN
   logic [127:0] bank [0:NR];
   logic         bank_ok;

   assign step     = req_key && bank_ok;
   assign step_key = bank[round_idx + 4'd1];

   always_ff @(posedge clk) begin
      if (load_acc)
         bank[0] <= key_in;
      if (state == EXPAND)
         bank[round_idx + 4'd1] <= exp_key;
   end

   always_ff @(posedge clk) begin
      if (!reset_n || load_acc)
         bank_ok <= 1'b0;
      else if (state == EXPAND && round_idx == LAST_STEP)
         bank_ok <= 1'b1;
   end
`else
   assign step     = req_key;
   assign step_key = exp_key;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load_key)
               state_nxt = LOAD_STATE;
         end
         ACTIVE: begin
            if (restart)
               state_nxt = ACTIVE;
            else if (step && round_idx == LAST_STEP)
               state_nxt = DONE;
         end
         DONE: begin
            if (load_key)
               state_nxt = LOAD_STATE;
            else if (restart)
               state_nxt = ACTIVE;
         end
`ifdef AES_KEY_PRECOMPUTE_EN
         EXPAND: begin
            if (round_idx == LAST_STEP)
               state_nxt = ACTIVE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      key_ready   = 1'b0;
      round_valid = 1'b0;
      sched_done  = 1'b0;
      case (state)
         IDLE:   key_ready = 1'b1;
         ACTIVE: round_valid = 1'b1;
         DONE: begin
            key_ready   = 1'b1;
            round_valid = 1'b1;
            sched_done  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         key_reg   <= '0;
         round_key <= '0;
         round_idx <= '0;
      end else if (load_acc) begin
         key_reg   <= key_in;
         round_key <= key_in;
         round_idx <= '0;
      end else begin
         case (state)
            ACTIVE, DONE: begin
               if (restart) begin
                  round_key <= key_reg;
                  round_idx <= '0;
               end else if (state == ACTIVE && step) begin
                  round_key <= step_key;
                  round_idx <= round_idx + 4'd1;
               end
            end
`ifdef AES_KEY_PRECOMPUTE_EN
            // round_key doubles as the expansion work register until the bank is full.
            EXPAND: begin
               if (round_idx == LAST_STEP) begin
                  round_key <= bank[0];
                  round_idx <= '0;
               end else begin
                  round_key <= exp_key;
                  round_idx <= round_idx + 4'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized bench for aes_key_schedule against a FIPS-197 word-recurrence model, plus directed known-answer checks.
module tb_aes_key_schedule;
   logic         clk = 1'b0;
   logic         reset_n;
   logic [127:0] key_in;
   logic         load_key;
   logic         key_ready;
   logic         req_key;
   logic         restart;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         round_valid;
   logic         sched_done;

`ifdef AES_KEY_PRECOMPUTE_EN
   localparam int EXP_CYC = 10;
`else
   localparam int EXP_CYC = 0;
`endif
   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K3  = 128'hffeeddccbbaa99887766554433221100;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   aes_key_schedule #(.NR(10)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_in      (key_in),
      .load_key    (load_key),
      .key_ready   (key_ready),
      .req_key     (req_key),
      .restart     (restart),
      .round_key   (round_key),
      .round_idx   (round_idx),
      .round_valid (round_valid),
      .sched_done  (sched_done)
   );

   always #5 clk = ~clk;

   // ---- reference model: S-box from GF(2^8) inverse + affine map ----
   logic [7:0]   sb [0:255];
   logic [31:0]  w [0:43];
   logic [127:0] m_sched [0:10];
   bit           m_present = 1'b0;
   logic [3:0]   m_idx = 4'd0;
   int           m_wait = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   end

   task automatic build_sched(input logic [127:0] k);
      logic [7:0]  rcv = 8'h01;
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcv, 24'h0};
            rcv = {rcv[6:0], 1'b0} ^ (rcv[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic bit m_ready();
      return !m_present || (m_wait == 0 && m_idx == 4'd10);
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_present = 1'b0;
         m_idx     = 4'd0;
         m_wait    = 0;
      end else if (m_ready() && load_key) begin
         build_sched(key_in);
         m_present = 1'b1;
         m_idx     = 4'd0;
         m_wait    = EXP_CYC;
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (m_present) begin
         if (restart) m_idx = 4'd0;
         else if (req_key && m_idx < 4'd10) m_idx++;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---- per-cycle compare against the model ----
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_valid;
         exp_valid = m_present && m_wait == 0;
         check("key_ready", 128'(key_ready), 128'(m_ready()));
         check("round_valid", 128'(round_valid), 128'(exp_valid));
         check("sched_done", 128'(sched_done), 128'(exp_valid && m_idx == 4'd10));
         if (exp_valid) begin
            check("round_idx", 128'(round_idx), 128'(m_idx));
            check("round_key", round_key, m_sched[m_idx]);
         end else if (!m_present) begin
            check("idle_idx", 128'(round_idx), 128'd0);
            check("idle_key", round_key, 128'd0);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !round_valid; i++) cyc();
      check("wait_valid", 128'(round_valid), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      load_key = 1'b0;
      req_key  = 1'b0;
      restart  = 1'b0;
      key_in   = '0;
      cyc();
      cyc();
      chk_en = 1'b1;
      check("rst_ready", 128'(key_ready), 128'd1);
      check("rst_valid", 128'(round_valid), 128'd0);
      check("rst_done", 128'(sched_done), 128'd0);
      check("rst_idx", 128'(round_idx), 128'd0);
      check("rst_key", round_key, 128'd0);

      reset_n = 1'b1;
      key_in = K1;
      load_key = 1'b1;
      cyc();
      load_key = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      wait_valid();
      check("load_key_val", round_key, K1);
      check("load_idx", 128'(round_idx), 128'd0);
      check("load_ready", 128'(key_ready), 128'd0);
      check("model_r1", m_sched[1], R1);
      check("model_r2", m_sched[2], R2);
      check("model_r10", m_sched[10], R10);

      req_key = 1'b1;
      cyc();
      req_key = 1'b0;
      check("step1_key", round_key, R1);
      check("step1_idx", 128'(round_idx), 128'd1);
      req_key = 1'b1;
      cyc();
      req_key = 1'b0;
      check("step2_key", round_key, R2);
      check("step2_idx", 128'(round_idx), 128'd2);

      req_key = 1'b1;
      repeat (8) cyc();
      check("full_key", round_key, R10);
      check("full_idx", 128'(round_idx), 128'd10);
      check("full_done", 128'(sched_done), 128'd1);
      check("full_ready", 128'(key_ready), 128'd1);
      repeat (2) cyc();
      req_key = 1'b0;
      check("hold_key", round_key, R10);
      check("hold_idx", 128'(round_idx), 128'd10);

      key_in = K2;
      load_key = 1'b1;
      cyc();
      load_key = 1'b0;
      wait_valid();
      check("done_load_key", round_key, K2);
      check("done_load_idx", 128'(round_idx), 128'd0);

      req_key = 1'b1;
      cyc();
      cyc();
      key_in = K3;
      load_key = 1'b1;
      cyc();
      load_key = 1'b0;
      cyc();
      cyc();
      check("gate_idx", 128'(round_idx), 128'd5);
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("restart_idx", 128'(round_idx), 128'd0);
      check("restart_key", round_key, K2);
      check("restart_done", 128'(sched_done), 128'd0);

      repeat (7) cyc();
      req_key = 1'b0;
      check("pre_rst_idx", 128'(round_idx), 128'd7);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      check("midrst_valid", 128'(round_valid), 128'd0);
      check("midrst_idx", 128'(round_idx), 128'd0);
      check("midrst_ready", 128'(key_ready), 128'd1);

      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom_range(0, 149) != 0);
         load_key = ($urandom_range(0, 7) == 0);
         req_key  = ($urandom_range(0, 3) != 0);
         restart  = ($urandom_range(0, 19) == 0);
         key_in   = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      reset_n  = 1'b1;
      load_key = 1'b0;
      req_key  = 1'b0;
      restart  = 1'b0;
      repeat (20) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
